// File: rtl/mantissa_mul_arbiter.sv
// rtl/mantissa_mul_arbiter.sv - two-port round-robin front end for a shared pipelined mantissa multiplier
`timescale 1ns/1ps
module mantissa_mul_arbiter #(
    parameter int LAT    = 2,
    parameter int RDEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [27:0] req0_a,
    input  logic [27:0] req0_b,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [27:0] req1_a,
    input  logic [27:0] req1_b,
    input  logic [1:0]  req1_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [55:0] rsp0_data,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [55:0] rsp1_data,
    output logic [27:0] mul_a,
    output logic [27:0] mul_b,
    output logic [1:0]  mul_op,
    input  logic [55:0] mul_out,
    output logic        idle
);
    localparam int AW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(RDEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    logic [1:0]     req_valid;
    logic [1:0]     eligible;
    logic [1:0]     grant;
    logic [1:0]     push;
    logic [1:0]     pop;
    logic [1:0]     rsp_ready_v;
    logic [1:0]     rsp_valid_v;
    logic           pick0;

    logic [CW-1:0]  fifo_count [2];
    logic [CW-1:0]  inflight   [2];
    logic [CW:0]    used       [2];
    logic [AW-1:0]  wr_ptr     [2];
    logic [AW-1:0]  rd_ptr     [2];
    logic [55:0]    fifo_mem   [2][RDEPTH];

    logic [LAT-1:0] tag_valid;
    logic [LAT-1:0] tag_port;
    logic           exit_valid;
    logic           exit_port;

    // last_grant = 1 means port 1 was served last, so port 0 wins the next tie
    logic           last_grant;

    assign req_valid   = {req1_valid, req0_valid};
    assign rsp_ready_v = {rsp1_ready, rsp0_ready};
    assign exit_valid  = tag_valid[LAT-1];
    assign exit_port   = tag_port[LAT-1];

    // Credit check from registered state only; a pop this cycle frees space next cycle
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            used[p]        = {1'b0, fifo_count[p]} + {1'b0, inflight[p]};
            eligible[p]    = req_valid[p] && (used[p] < DEPTH_W);
            rsp_valid_v[p] = (fifo_count[p] != '0);
            push[p]        = exit_valid && (exit_port == 1'(p));
            pop[p]         = rsp_valid_v[p] && rsp_ready_v[p];
        end
    end

    assign pick0 = eligible[0] && (!eligible[1] || last_grant);

    // Round-robin grant, suppressed while reset is held
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            grant[0] = pick0;
            grant[1] = eligible[1] && !pick0;
        end
    end

    // Operand registers toward the multiplier; they hold until the next grant
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a      <= '0;
            mul_b      <= '0;
            mul_op     <= '0;
            last_grant <= 1'b1;
        end else if (grant[0]) begin
            mul_a      <= req0_a;
            mul_b      <= req0_b;
            mul_op     <= req0_op;
            last_grant <= 1'b0;
        end else if (grant[1]) begin
            mul_a      <= req1_a;
            mul_b      <= req1_b;
            mul_op     <= req1_op;
            last_grant <= 1'b1;
        end
    end

    // Tag pipeline tracking which port owns the product emerging LAT cycles later
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
            tag_port  <= '0;
        end else begin
            tag_valid[0] <= |grant;
            tag_port[0]  <= grant[1];
            for (int i = 1; i < LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_port[i]  <= tag_port[i-1];
            end
        end
    end

    // Per-port in-flight counters, FIFO occupancy and pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                inflight[p]   <= '0;
                fifo_count[p] <= '0;
                wr_ptr[p]     <= '0;
                rd_ptr[p]     <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                case ({grant[p], push[p]})
                    2'b10:   inflight[p] <= inflight[p] + ONE_C;
                    2'b01:   inflight[p] <= inflight[p] - ONE_C;
                    default: inflight[p] <= inflight[p];
                endcase
                case ({push[p], pop[p]})
                    2'b10:   fifo_count[p] <= fifo_count[p] + ONE_C;
                    2'b01:   fifo_count[p] <= fifo_count[p] - ONE_C;
                    default: fifo_count[p] <= fifo_count[p];
                endcase
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + ONE_A;
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + ONE_A;
            end
        end
    end

    // Response storage; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) fifo_mem[p][wr_ptr[p]] <= mul_out;
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = rsp_valid_v[0];
    assign rsp1_valid = rsp_valid_v[1];
    assign rsp0_data  = fifo_mem[0][rd_ptr[0]];
    assign rsp1_data  = fifo_mem[1][rd_ptr[1]];
    assign idle       = (tag_valid == '0) && (fifo_count[0] == '0) && (fifo_count[1] == '0);

endmodule

// File: tb/tb_mantissa_mul_arbiter.sv
// tb/tb_mantissa_mul_arbiter.sv - directed self-checking bench for mantissa_mul_arbiter
`timescale 1ns/1ps
module tb_mantissa_mul_arbiter;
    localparam int LAT    = 2;
    localparam int RDEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [27:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [55:0] rsp0_data, rsp1_data;
    logic [27:0] mul_a, mul_b;
    logic [1:0]  mul_op;
    logic [55:0] mul_out;
    logic [55:0] mul_q;
    logic        idle;

    int          checks;
    int          errors;
    int          n0, n1, c0, c1;
    logic        acc0, acc1;
    logic [55:0] exp0 [$];
    logic [55:0] exp1 [$];

    mantissa_mul_arbiter #(.LAT(LAT), .RDEPTH(RDEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_op     (mul_op),
        .mul_out    (mul_out),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    // Multiplier model: one register after the DUT's operand register gives LAT=2
    always @(posedge clk) mul_q <= {28'b0, mul_a} * {28'b0, mul_b};
    assign mul_out = mul_q;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [55:0] prod(input logic [27:0] a, input logic [27:0] b);
        return {28'b0, a} * {28'b0, b};
    endfunction

    task automatic set_ops0();
        req0_a = 28'h0000100 + 28'(n0 * 17);
        req0_b = 28'h0000003 + 28'(n0);
    endtask

    task automatic set_ops1();
        req1_a = 28'hFFFFFFF - 28'(n1);
        req1_b = 28'h0000002 + 28'(n1 * 2);
    endtask

    // One clock: observe acceptance at the negedge, advance operands after the edge
    task automatic step();
        @(negedge clk);
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
        if (acc0) begin n0++; set_ops0(); end
        if (acc1) begin n1++; set_ops1(); end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        while (!idle && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle"}, idle, 1);
        check({tag, "_q0_empty"}, exp0.size(), 0);
        check({tag, "_q1_empty"}, exp1.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: record accepted requests, compare every visible response head
    always @(negedge clk) begin
        if (rst) begin
            exp0.delete();
            exp1.delete();
        end else begin
            if (req0_valid && req0_ready) exp0.push_back(prod(req0_a, req0_b));
            if (req1_valid && req1_ready) exp1.push_back(prod(req1_a, req1_b));
            if (req0_ready && req1_ready) check("one_grant", 1, 0);
            if (rsp0_valid) begin
                if (exp0.size() == 0) check("rsp0_extra", 1, 0);
                else begin
                    check("rsp0_data", rsp0_data, exp0[0]);
                    if (rsp0_ready) void'(exp0.pop_front());
                end
            end
            if (rsp1_valid) begin
                if (exp1.size() == 0) check("rsp1_extra", 1, 0);
                else begin
                    check("rsp1_data", rsp1_data, exp1[0]);
                    if (rsp1_ready) void'(exp1.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int k;
        checks = 0;
        errors = 0;
        n0 = 0;
        n1 = 0;

        // Reset state, with requests held valid to show grants are gated
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 28'h0000003; req0_b = 28'h0000005; req0_op = 2'b00;
        req1_valid = 1'b1; req1_a = 28'h0000007; req1_b = 28'h0000009; req1_op = 2'b01;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_mul_op", mul_op, 0);
        check("rst_idle", idle, 1);

        // Single request 3*5 with LAT=2
        @(posedge clk);
        #1;
        rst = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("t1_ready", req0_ready, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        check("t1_mul_a", mul_a, 28'h0000003);
        check("t1_mul_b", mul_b, 28'h0000005);
        check("t1_mul_op", mul_op, 2'b00);
        check("t1_rsp_e0", rsp0_valid, 0);
        check("t1_busy", idle, 0);
        @(negedge clk);
        check("t1_rsp_e1", rsp0_valid, 0);
        @(negedge clk);
        check("t1_rsp_e2", rsp0_valid, 1);
        check("t1_data", rsp0_data, 56'h0F);
        @(negedge clk);
        check("t1_stall_data", rsp0_data, 56'h0F);
        @(posedge clk);
        #1;
        rsp0_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t1_popped", rsp0_valid, 0);
        check("t1_idle", idle, 1);

        // Both ports saturating, alternation from reset
        n0 = 0; n1 = 0;
        set_ops0(); set_ops1();
        req0_op = 2'b01; req1_op = 2'b10;
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr_grant", {acc1, acc0}, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        drain("t2");

        // Port 1 stalled: credits cap it at RDEPTH, port 0 keeps full rate
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b0;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            c0 += int'(acc0);
            c1 += int'(acc1);
        end
        check("t3_acc1", c1, 4);
        check("t3_acc0", c0, 12);
        @(negedge clk);
        check("t3_blocked", req1_ready, 0);
        check("t3_rsp1_held", rsp1_valid, 1);
        @(posedge clk);
        #1;
        rsp1_ready = 1'b1;
        step();
        rsp1_ready = 1'b0;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            c0 += int'(acc0);
            c1 += int'(acc1);
        end
        check("t3_one_more_acc1", c1, 1);
        check("t3_acc0_after", c0, 7);
        drain("t3");

        // Reset with two operations in flight
        do_reset();
        req0_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        step();
        step();
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t4_ready_gated", req0_ready, 0);
        check("t4_rsp0_valid", rsp0_valid, 0);
        check("t4_idle", idle, 1);
        check("t4_mul_a", mul_a, 0);
        check("t4_mul_op", mul_op, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req0_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_no_rsp", rsp0_valid, 0);
            check("t4_still_idle", idle, 1);
        end
        @(posedge clk);
        #1;

        // op=2'b11 passes through, largest mantissas
        req1_a = 28'hFFFFFFF; req1_b = 28'hFFFFFFF; req1_op = 2'b11;
        req1_valid = 1'b1;
        rsp1_ready = 1'b0;
        step();
        req1_valid = 1'b0;
        check("t5_acc", acc1, 1);
        @(negedge clk);
        check("t5_mul_op", mul_op, 2'b11);
        check("t5_mul_a", mul_a, 28'hFFFFFFF);
        k = 0;
        while (!rsp1_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("t5_rsp_valid", rsp1_valid, 1);
        check("t5_rsp_data", rsp1_data, 56'hFFFFFFE0000001);
        @(posedge clk);
        #1;
        drain("t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
